// File: rtl/vpu_dst_port.sv
// VPU destination port: packs EXEC_CNT VLANE result beats into one SRAM word and writes it.
// Optional ack timeout with sticky err_o is enabled by defining VPU_DST_PORT_ACK_TIMEOUT_EN.
module vpu_dst_port #(
  parameter int DWIDTH_PER_EXEC = 128,
  parameter int EXEC_CNT        = 2,
  parameter int ADDR_WIDTH      = 10
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 64
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                dst_valid_i,
  input  logic [ADDR_WIDTH-1:0]               waddr_i,
  output logic                                done_o,
  input  logic                                result_valid_i,
  input  logic [DWIDTH_PER_EXEC-1:0]          result_data_i,
  output logic                                result_ready_o,
  output logic                                sram_req_o,
  output logic [ADDR_WIDTH-1:0]               sram_addr_o,
  output logic [DWIDTH_PER_EXEC*EXEC_CNT-1:0] sram_wdata_o,
  input  logic                                sram_ack_i
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
  ,
  output logic                                err_o
`endif
);

  localparam int SW    = DWIDTH_PER_EXEC * EXEC_CNT;
  localparam int CNT_W = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SW-1:0]           buf_q, buf_d;

`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = waddr_i;
          state_d = dst_valid_i ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        if (result_valid_i) begin
          buf_d[int'(cnt_q)*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = result_data_i;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (sram_ack_i) begin
          state_d = S_DONE;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign result_ready_o = (state_q == S_COLLECT);
  assign sram_req_o     = (state_q == S_WRITE);
  assign done_o         = (state_q == S_DONE);
  assign sram_addr_o    = sram_req_o ? addr_q : '0;
  assign sram_wdata_o   = sram_req_o ? buf_q : '0;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
  assign err_o          = err_q;
`endif

endmodule

// File: tb/tb_vpu_dst_port.sv
// Self-checking bench for vpu_dst_port: vector table, randomized transactions, reset and timeout sequences.
// Expected per-cycle outputs come from a transaction schedule model computed arithmetically.
module tb_vpu_dst_port;

  localparam int DW  = 128;
  localparam int EC  = 2;
  localparam int AW  = 10;
  localparam int SW  = DW * EC;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          dst_valid_i;
  logic [AW-1:0] waddr_i;
  logic          done_o;
  logic          result_valid_i;
  logic [DW-1:0] result_data_i;
  logic          result_ready_o;
  logic          sram_req_o;
  logic [AW-1:0] sram_addr_o;
  logic [SW-1:0] sram_wdata_o;
  logic          sram_ack_i;
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
  logic          err_o;
`endif
  logic          err_exp = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vpu_dst_port #(
    .DWIDTH_PER_EXEC(DW),
    .EXEC_CNT       (EC),
    .ADDR_WIDTH     (AW)
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .dst_valid_i   (dst_valid_i),
    .waddr_i       (waddr_i),
    .done_o        (done_o),
    .result_valid_i(result_valid_i),
    .result_data_i (result_data_i),
    .result_ready_o(result_ready_o),
    .sram_req_o    (sram_req_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_ack_i    (sram_ack_i)
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
    ,
    .err_o         (err_o)
`endif
  );

  typedef struct {
    logic          dst;
    logic [AW-1:0] addr;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    int            g0;
    int            g1;
    int            d;
    bit            noise;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input string ctx, input int cyc,
                       input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%s cyc %0d]: got %h expected %h", nm, ctx, cyc, act, exp);
    end
  endtask

  task automatic drive_idle();
    start_i        = 1'b0;
    dst_valid_i    = 1'b0;
    waddr_i        = '0;
    result_valid_i = 1'b0;
    result_data_i  = '0;
    sram_ack_i     = 1'b0;
  endtask

  task automatic check_all(input string ctx, input int cyc, input logic rdy, input logic req,
                           input logic dn, input logic [AW-1:0] ad, input logic [SW-1:0] wd);
    check("result_ready_o", ctx, cyc, SW'(result_ready_o), SW'(rdy));
    check("sram_req_o",     ctx, cyc, SW'(sram_req_o),     SW'(req));
    check("done_o",         ctx, cyc, SW'(done_o),         SW'(dn));
    check("sram_addr_o",    ctx, cyc, SW'(sram_addr_o),    SW'(ad));
    check("sram_wdata_o",   ctx, cyc, sram_wdata_o,        wd);
`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
    check("err_o",          ctx, cyc, SW'(err_o),          SW'(err_exp));
`endif
  endtask

  task automatic idle_cycles(input string ctx, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_all(ctx, i, 1'b0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // One transaction. Cycle 0 carries start_i; beat i arrives after g_i idle cycles;
  // ack comes after d refused request cycles (or never when no_ack).
  task automatic run_txn(input string ctx, input logic dst, input logic [AW-1:0] addr,
                         input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                         input int g0, input int g1, input int d, input bit noise, input bit no_ack);
    int bc0, bc1, c, d_eff, lat;
    logic rdy, req, dn;
    logic [SW-1:0] word;
    bc0   = 1 + g0;
    bc1   = bc0 + 1 + g1;
    c     = bc1;
    d_eff = no_ack ? TMO - 1 : d;
    lat   = dst ? c + d_eff + 2 : 1;
    word  = {b1, b0};
    for (int cyc = 0; cyc <= lat + 1; cyc++) begin
      @(posedge clk); #1;
      drive_idle();
      if (cyc == 0) begin
        start_i     = 1'b1;
        dst_valid_i = dst;
        waddr_i     = addr;
      end else if (noise && cyc <= lat) begin
        start_i     = 1'b1;
        dst_valid_i = 1'b1;
        waddr_i     = '1;
      end
      if (dst && cyc == bc0) begin
        result_valid_i = 1'b1;
        result_data_i  = b0;
      end else if (dst && cyc == bc1) begin
        result_valid_i = 1'b1;
        result_data_i  = b1;
      end else if (noise && !(dst && cyc >= 1 && cyc <= c)) begin
        result_valid_i = 1'b1;
        result_data_i  = {4{$urandom}};
      end
      if (dst && !no_ack && cyc == c + 1 + d) sram_ack_i = 1'b1;
      @(negedge clk);
      rdy = dst && cyc >= 1 && cyc <= c;
      req = dst && cyc >= c + 1 && cyc <= c + 1 + d_eff;
      dn  = (cyc == lat);
      if (no_ack && dn) err_exp = 1'b1;
      check_all(ctx, cyc, rdy, req, dn, req ? addr : '0, req ? word : '0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h05A, {16{8'h11}}, {16{8'h22}}, 0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 10'h133, {4{32'hCAFEF00D}}, {4{32'h0BADBEEF}}, 0, 3, 5, 1'b0};
    tbl[2] = '{1'b0, 10'h0F0, {4{32'h12345678}}, {4{32'h9ABCDEF0}}, 0, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 10'h044, {16{8'h5A}}, {16{8'hA5}}, 1, 0, 2, 1'b1};
    tbl[4] = '{1'b1, 10'h3FE, {4{32'h600DF00D}}, {4{32'hFEEDFACE}}, 0, 0, TMO - 1, 1'b0};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles("post_reset", 2);

    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].dst, tbl[i].addr, tbl[i].b0, tbl[i].b1,
              tbl[i].g0, tbl[i].g1, tbl[i].d, tbl[i].noise, 1'b0);
      $display("[TB] vector %0d done, %0d checks so far", i, tests_run);
    end

    for (int i = 0; i < 30; i++) begin
      logic dst;
      logic [AW-1:0] addr;
      logic [DW-1:0] b0, b1;
      dst  = ($urandom_range(0, 3) != 0);
      addr = AW'($urandom);
      b0   = {$urandom, $urandom, $urandom, $urandom};
      b1   = {$urandom, $urandom, $urandom, $urandom};
      run_txn($sformatf("rand%0d", i), dst, addr, b0, b1, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)), 1'b0);
      $display("[TB] random txn %0d dst=%0d addr=%h", i, dst, addr);
    end

    // Reset after beat 0 is accepted: no write may follow, outputs must clear.
    @(posedge clk); #1;
    drive_idle();
    start_i = 1'b1; dst_valid_i = 1'b1; waddr_i = 10'h020;
    @(posedge clk); #1;
    drive_idle();
    result_valid_i = 1'b1; result_data_i = {4{32'hDEADBEEF}};
    @(negedge clk);
    check("ready_before_rst", "rst_mid", 1, SW'(result_ready_o), SW'(1'b1));
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    result_valid_i = 1'b1; result_data_i = {4{32'h0DDC0FFE}};
    @(posedge clk); #1;
    rst = 1'b0;
    result_valid_i = 1'b0;
    @(negedge clk);
    check_all("rst_mid", 3, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycles("rst_mid_idle", 4);
    run_txn("after_rst", 1'b1, 10'h021, {16{8'hAA}}, {16{8'hBB}}, 0, 0, 1, 1'b0, 1'b0);
    $display("[TB] reset mid-operation sequence done");

`ifdef VPU_DST_PORT_ACK_TIMEOUT_EN
    run_txn("timeout", 1'b1, 10'h155, {16{8'hC3}}, {16{8'h3C}}, 0, 0, 0, 1'b0, 1'b1);
    idle_cycles("err_sticky", 3);
    run_txn("post_timeout", 1'b1, 10'h156, {16{8'h01}}, {16{8'h02}}, 0, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all("err_clear", 0, 1'b0, 1'b0, 1'b0, '0, '0);
    $display("[TB] timeout sequence done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
